des_key_verifier: RTL and testbench

- Iterative DES decryption engine that confirms a key reported by the brute-force search top level.
- Takes the candidate Key and the captured ciphertext, decrypts in 16 Feistel rounds, and compares the recovered block with the expected plaintext.
- Drives a registered Match/Done result back to the control/reporting logic.
- It is the decrypt direction of the search engine's encrypt-and-compare path, so no found key is reported without independent confirmation.

---
 rtl/des_pkg.sv | 124 ++++++++++++
 rtl/des_f.sv | 24 ++
 rtl/des_key_verifier.sv | 141 ++++++++++++++
 tb/tb_des_key_verifier.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// DES tables, state/block types and bit-permutation helpers for the key verifier.
// Table entries use DES bit numbering: bit 1 is the MSB of each word.
package des_pkg;

  typedef logic [63:0] des_block_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL} des_state_t;

  localparam int IP_TAB [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

  localparam int FP_TAB [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_TAB [48] = '{
    32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

  localparam int P_TAB [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

  // Right-rotate applied to C/D before each decrypt round forms its subkey.
  localparam int ROT_SCHED [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Indexed [box][row*16 + col].
  localparam int SBOX [8][64] = '{
    '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
       0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
       4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
      15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
    '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
       3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
       0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
      13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
    '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
      13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
      13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
       1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
    '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
      13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
      10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
       3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
    '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
      14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
       4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
      11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
    '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
      10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
       9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
       4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
    '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
      13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
       1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
       6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
    '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
       1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
       7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
       2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}};

  function automatic des_block_t ip_perm(input des_block_t x);
    des_block_t y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - IP_TAB[i])];
    return y;
  endfunction

  function automatic des_block_t fp_perm(input des_block_t x);
    des_block_t y;
    for (int i = 0; i < 64; i++) y[6'(63 - i)] = x[6'(64 - FP_TAB[i])];
    return y;
  endfunction

  function automatic logic [47:0] e_expand(input logic [31:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[5'(32 - E_TAB[i])];
    return y;
  endfunction

  function automatic logic [31:0] p_perm(input logic [31:0] x);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) y[5'(31 - i)] = x[5'(32 - P_TAB[i])];
    return y;
  endfunction

  function automatic logic [55:0] pc1_perm(input des_block_t x);
    logic [55:0] y;
    for (int i = 0; i < 56; i++) y[6'(55 - i)] = x[6'(64 - PC1_TAB[i])];
    return y;
  endfunction

  function automatic logic [47:0] pc2_perm(input logic [55:0] x);
    logic [47:0] y;
    for (int i = 0; i < 48; i++) y[6'(47 - i)] = x[6'(56 - PC2_TAB[i])];
    return y;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input int n);
    case (n)
      1:       return {x[0], x[27:1]};
      2:       return {x[1:0], x[27:2]};
      default: return x;
    endcase
  endfunction

endpackage

// File: rtl/des_f.sv
// DES round function: E-expansion, subkey mix, S-box substitution and P permutation.
module des_f
  import des_pkg::*;
(
  input  logic [31:0] r,
  input  logic [47:0] subkey,
  output logic [31:0] f
);

  logic [47:0] x;
  logic [31:0] s_out;

  assign x = e_expand(r) ^ subkey;

  // Outer bits select the row, inner four bits the column.
  for (genvar gi = 0; gi < 8; gi++) begin : g_sbox
    logic [5:0] b;
    assign b = x[47 - 6*gi -: 6];
    assign s_out[31 - 4*gi -: 4] = 4'(SBOX[gi][{b[5], b[0], b[4:1]}]);
  end

  assign f = p_perm(s_out);

endmodule

// File: rtl/des_key_verifier.sv
// Iterative DES decryptor confirming a candidate key against a known plaintext.
// Define DES_VERIFY_PARITY_EN to add the ParityErr output and gate Match on key parity.
module des_key_verifier
  import des_pkg::*;
#(
  parameter int ROUNDS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [63:0] Key,
  input  logic [63:0] ciphertext,
  input  logic [63:0] plaintext,
  output logic        Busy,
  output logic        Done,
  output logic        Match,
  output logic [63:0] Recovered
`ifdef DES_VERIFY_PARITY_EN
  ,
  output logic        ParityErr
`endif
);

  localparam int RPC = ROUNDS_PER_CYCLE;

  if (RPC != 1 && RPC != 2 && RPC != 4) begin : g_bad_rpc
    $error("des_key_verifier: ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  des_state_t  state_reg;
  logic [4:0]  cnt_reg;
  logic [31:0] l_reg, r_reg;
  logic [27:0] c_reg, d_reg;
  des_block_t  pt_reg;
  des_block_t  rec_reg;
  logic        busy_reg, done_reg, match_reg;
  logic        perr_reg;
  logic        key_perr;
  des_block_t  fp_out;

  logic [31:0] l_st [RPC+1];
  logic [31:0] r_st [RPC+1];
  logic [27:0] c_st [RPC+1];
  logic [27:0] d_st [RPC+1];

  assign l_st[0] = l_reg;
  assign r_st[0] = r_reg;
  assign c_st[0] = c_reg;
  assign d_st[0] = d_reg;

  // Each stage rotates C/D for its own round before deriving the subkey.
  for (genvar gi = 0; gi < RPC; gi++) begin : g_round
    logic [3:0]  rnd;
    logic [27:0] c_rot, d_rot;
    logic [47:0] subkey;
    logic [31:0] f_out;

    assign rnd    = cnt_reg[3:0] + 4'(gi);
    assign c_rot  = rotr28(c_st[gi], ROT_SCHED[rnd]);
    assign d_rot  = rotr28(d_st[gi], ROT_SCHED[rnd]);
    assign subkey = pc2_perm({c_rot, d_rot});

    des_f u_f (
      .r      (r_st[gi]),
      .subkey (subkey),
      .f      (f_out)
    );

    assign l_st[gi+1] = r_st[gi];
    assign r_st[gi+1] = l_st[gi] ^ f_out;
    assign c_st[gi+1] = c_rot;
    assign d_st[gi+1] = d_rot;
  end

`ifdef DES_VERIFY_PARITY_EN
  logic [7:0] byte_even;
  for (genvar gi = 0; gi < 8; gi++) begin : g_parity
    assign byte_even[gi] = ~^Key[8*gi +: 8];
  end
  assign key_perr  = |byte_even;
  assign ParityErr = perr_reg;
`else
  assign key_perr = 1'b0;
`endif

  assign fp_out = fp_perm({r_reg, l_reg});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      l_reg     <= '0;
      r_reg     <= '0;
      c_reg     <= '0;
      d_reg     <= '0;
      pt_reg    <= '0;
      rec_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      match_reg <= 1'b0;
      perr_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Start) begin
            {l_reg, r_reg} <= ip_perm(ciphertext);
            {c_reg, d_reg} <= pc1_perm(Key);
            pt_reg         <= plaintext;
            perr_reg       <= key_perr;
            cnt_reg        <= '0;
            busy_reg       <= 1'b1;
            state_reg      <= ROUND;
          end
        end
        ROUND: begin
          l_reg   <= l_st[RPC];
          r_reg   <= r_st[RPC];
          c_reg   <= c_st[RPC];
          d_reg   <= d_st[RPC];
          cnt_reg <= cnt_reg + 5'(RPC);
          if (cnt_reg == 5'(16 - RPC)) state_reg <= FINAL;
        end
        FINAL: begin
          rec_reg   <= fp_out;
          match_reg <= (fp_out == pt_reg) && !perr_reg;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Busy      = busy_reg;
  assign Done      = done_reg;
  assign Match     = match_reg;
  assign Recovered = rec_reg;

endmodule

// File: tb/tb_des_key_verifier.sv
// Randomised bench for des_key_verifier against a textbook DES decryption model.
// Build with DES_VERIFY_PARITY_EN defined to exercise the ParityErr output.
module tb_des_key_verifier;
  import des_pkg::*;

  parameter int RPC = 1;
  localparam int LAT     = 16 / RPC + 1;
  localparam int EXP_LAT = (RPC == 4) ? 5 : (RPC == 2) ? 9 : 17;

  localparam logic [63:0] V1_KEY = 64'h133457799BBCDFF1;
  localparam logic [63:0] V1_CT  = 64'h85E813540F0AB405;
  localparam logic [63:0] V1_PT  = 64'h0123456789ABCDEF;
  localparam logic [63:0] V2_KEY = 64'h0E329232EA6D0D73;
  localparam logic [63:0] V2_CT  = 64'h0000000000000000;
  localparam logic [63:0] V2_PT  = 64'h8787878787878787;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [63:0] key = '0, ct = '0, pt = '0;
  logic        busy, done, match;
  logic [63:0] rec;
  logic        perr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit chk_en = 0;
  int dut_dones = 0;
  int m_dones = 0;

  des_key_verifier #(.ROUNDS_PER_CYCLE(RPC)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .Start      (start),
    .Key        (key),
    .ciphertext (ct),
    .plaintext  (pt),
    .Busy       (busy),
    .Done       (done),
    .Match      (match),
    .Recovered  (rec)
`ifdef DES_VERIFY_PARITY_EN
    ,
    .ParityErr  (perr)
`endif
  );

`ifndef DES_VERIFY_PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- textbook DES model (encrypt-order key schedule) ----------------
  function automatic logic [31:0] m_f(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, y;
    logic [5:0]  six;
    int v;
    for (int i = 0; i < 48; i++) x[47 - i] = r[32 - E_TAB[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six = x[47 - 6*b -: 6];
      v = SBOX[b][(six[5] * 2 + six[0]) * 16 + six[4:1]];
      s[31 - 4*b -: 4] = v[3:0];
    end
    for (int i = 0; i < 32; i++) y[31 - i] = s[32 - P_TAB[i]];
    return y;
  endfunction

  function automatic logic [63:0] m_decrypt(input logic [63:0] k, input logic [63:0] c);
    int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
    logic [55:0] cd;
    logic [27:0] cc, dd;
    logic [47:0] ks [1:16];
    logic [63:0] blk, pre, out;
    logic [31:0] l, r, t;
    for (int i = 0; i < 56; i++) cd[55 - i] = k[64 - PC1_TAB[i]];
    cc = cd[55:28];
    dd = cd[27:0];
    for (int n = 1; n <= 16; n++) begin
      for (int s = 0; s < shifts[n-1]; s++) begin
        cc = {cc[26:0], cc[27]};
        dd = {dd[26:0], dd[27]};
      end
      cd = {cc, dd};
      for (int i = 0; i < 48; i++) ks[n][47 - i] = cd[56 - PC2_TAB[i]];
    end
    for (int i = 0; i < 64; i++) blk[63 - i] = c[64 - IP_TAB[i]];
    l = blk[63:32];
    r = blk[31:0];
    for (int n = 16; n >= 1; n--) begin
      t = r;
      r = l ^ m_f(r, ks[n]);
      l = t;
    end
    pre = {r, l};
    for (int i = 0; i < 64; i++) out[63 - i] = pre[64 - FP_TAB[i]];
    return out;
  endfunction

  function automatic bit m_parity_bad(input logic [63:0] k);
    for (int b = 0; b < 8; b++) if (^k[8*b +: 8] == 1'b0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] make_odd(input logic [63:0] k);
    logic [63:0] y = k;
    for (int b = 0; b < 8; b++) if (^y[8*b +: 8] == 1'b0) y[8*b] = ~y[8*b];
    return y;
  endfunction

  // ---------------- cycle-level expectation: edges remaining until Done ----------------
  int          m_left = 0;
  bit          m_done = 0, m_match = 0, m_perr = 0, p_match = 0;
  logic [63:0] m_rec = '0, p_rec = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_done = 0; m_match = 0; m_perr = 0; m_rec = '0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1; m_rec = p_rec; m_match = p_match; m_dones++;
        end
      end else if (start) begin
        m_left = LAT;
        p_rec  = m_decrypt(key, ct);
`ifdef DES_VERIFY_PARITY_EN
        m_perr  = m_parity_bad(key);
        p_match = (p_rec == pt) && !m_perr;
`else
        p_match = (p_rec == pt);
`endif
      end
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b required %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check1("busy", busy, m_left > 0);
      check1("done", done, m_done);
      check1("match", match, m_match);
      check64("recovered", rec, m_rec);
`ifdef DES_VERIFY_PARITY_EN
      check1("parityerr", perr, m_perr);
`endif
      if (done === 1'b1) begin
        dut_dones++;
        $display("txn %0d: cycle=%0d recovered=%h match=%0b parity_err=%0b",
                 dut_dones, cyc, rec, match, perr);
      end
    end
  end

  // Drive a request; returns 1 ns after the accepting edge.
  task automatic issue(input logic [63:0] k, input logic [63:0] c, input logic [63:0] p);
    key = k; ct = c; pt = p; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    acc_cyc = cyc;
  endtask

  // Returns at the negedge where Done is seen; checks latency from acceptance.
  task automatic wait_done(input string name);
    int n = 0;
    int lat;
    do begin
      @(negedge clk); n++;
    end while (done !== 1'b1 && n < 60);
    lat = (done === 1'b1) ? (cyc - acc_cyc) : -1;
    checks++;
    if (lat != EXP_LAT) begin
      failures++;
      $display("FAIL %s_latency: got %0d cycles required %0d (-1 = no Done)", name, lat, EXP_LAT);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] k, c, p;

    #2 rst_n = 1'b0;
    #1 chk_en = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check1("reset_busy", busy, 1'b0);
    check64("reset_recovered", rec, 64'h0);

    // Hand-derived vectors pin the model itself.
    check64("model_v1", m_decrypt(V1_KEY, V1_CT), V1_PT);
    check64("model_v2", m_decrypt(V2_KEY, V2_CT), V2_PT);

    // Vector 1: match.
    issue(V1_KEY, V1_CT, V1_PT);
    wait_done("t1");
    check1("t1_match", match, 1'b1);
    check64("t1_recovered", rec, 64'h0123456789ABCDEF);

    // Wrong expected plaintext.
    issue(V1_KEY, V1_CT, 64'h0123456789ABCDEE);
    wait_done("t3");
    check1("t3_match", match, 1'b0);
    check64("t3_recovered", rec, 64'h0123456789ABCDEF);

    // Start while busy is ignored; Start during Done cycle is accepted.
    issue(V1_KEY, V1_CT, V1_PT);
    repeat (RPC == 4 ? 2 : 4) @(posedge clk);
    #1 key = V2_KEY; ct = V2_CT; pt = V2_PT; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t4a");
    check64("t4a_recovered", rec, V1_PT);
    issue(V2_KEY, V2_CT, V2_PT);
    wait_done("t4b");
    check1("t4b_match", match, 1'b1);
    check64("t4b_recovered", rec, 64'h8787878787878787);

    // Reset mid-operation aborts immediately.
    issue(V1_KEY, V1_CT, V1_PT);
    repeat (RPC == 4 ? 2 : 7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check1("t5_busy", busy, 1'b0);
    check1("t5_done", done, 1'b0);
    check1("t5_match", match, 1'b0);
    check64("t5_recovered", rec, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    #1;
    issue(V1_KEY, V1_CT, V1_PT);
    wait_done("t5b");
    check1("t5b_match", match, 1'b1);

`ifdef DES_VERIFY_PARITY_EN
    issue(64'h133457799BBCDFF0, V1_CT, V1_PT);
    wait_done("t6a");
    check1("t6a_parityerr", perr, 1'b1);
    check1("t6a_match", match, 1'b0);
    issue(V1_KEY, V1_CT, V1_PT);
    wait_done("t6b");
    check1("t6b_parityerr", perr, 1'b0);
    check1("t6b_match", match, 1'b1);
`else
    // Parity bits are discarded by PC-1.
    issue(V1_KEY ^ 64'h0101010101010101, V1_CT, V1_PT);
    wait_done("t6p");
    check1("t6p_match", match, 1'b1);
`endif

    // Randomised traffic: inputs scrambled after acceptance, stray Starts while busy.
    for (int i = 0; i < 30; i++) begin
      k = {$urandom, $urandom};
      c = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) k = make_odd(k);
      p = ($urandom_range(0, 1) == 1) ? m_decrypt(k, c) : {$urandom, $urandom};
      issue(k, c, p);
      key = {$urandom, $urandom}; ct = {$urandom, $urandom}; pt = {$urandom, $urandom};
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, LAT - 2)) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
      end
      wait_done("rand");
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (LAT + 3) @(negedge clk);
    checks++;
    if (dut_dones != m_dones) begin
      failures++;
      $display("FAIL done_count: got %0d pulses required %0d", dut_dones, m_dones);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
